frame_update_scheduler: RTL and testbench
=========================================

// Module: frame_update_scheduler
// PURPOSE
//  Sequences per-frame game-object updates (asteroid mover, defense, planet state, ...) into vertical blanking.
//  Watches the VGA HCounter/VCounter and detects the start of vblank. At vblank start it snapshots the
//  requesters and grants the update slot round-robin, one requester at a time.
//  Sits between HorizentalVerticalControl and the object/draw modules so that object state never changes mid-scan.
// PARAMETERS
//  N_REQ           4     number of update requesters
//  V_ACTIVE_START  36    first visible line
//  V_ACTIVE_END    515   last visible line; vblank starts at V_ACTIVE_END+1
//  TIMEOUT         4095  max clk cycles one grant may be held
// PORTS
//  clk          in   1      system clock; counters advance at a divided rate, so a value persists many clk cycles
//  rst_n        in   1      asynchronous, active-low reset
//  enable       in   1      1 = schedule updates each frame
//  HCounter     in   10     horizontal pixel counter
//  VCounter     in   10     vertical line counter
//  req          in   N_REQ  requester i wants an update slot this frame (level)
//  done         in   N_REQ  requester i finished (1-cycle pulse or level)
//  clr_overrun  in   1      clears the sticky overrun flag
//  grant        out  N_REQ  one-hot (or zero) update permission
//  frame_tick   out  1      1-cycle pulse at vblank start
//  busy         out  1      1 when state != IDLE
//  overrun      out  1      sticky error flag
//  frame_count  out  8      frames scheduled, wraps 255->0
// BEHAVIOUR
//  - Reset (async, rst_n=0): grant=0, frame_tick=0, busy=0, overrun=0, frame_count=0, rr_ptr=N_REQ-1,
//    pending=0, state=IDLE. Reset mid-grant drops grant immediately.
//  - Vblank detect: vb = (VCounter==V_ACTIVE_END+1 && HCounter==0). vb is registered into vb_q.
//    Event on cycle D when vb=1 and vb_q=0. Exactly one event per frame, however long the counters hold.
//  - On an event at D: frame_tick=1 during D+1 only; frame_count increments at D+1 regardless of enable.
//  - FSM states IDLE, ARB, SERVE.
//    IDLE: if event and enable: pending <= req, state <= ARB at D+1.
//          If event and !enable: stay in IDLE.
//    ARB: select the first set pending bit searching rr_ptr+1, rr_ptr+2, ... (mod N_REQ).
//         If a bit is found: grant <= onehot(i), state <= SERVE; grant is visible at D+2.
//         If none is found: state <= IDLE.
//    SERVE: hold grant until done[i]=1 for the granted i. On that cycle: grant <= 0, pending[i] <= 0,
//           rr_ptr <= i, state <= ARB. The next grant therefore appears 2 cycles after the done.
//  - done on non-granted lines is ignored. A req that drops after the snapshot keeps its pending slot;
//    a req that rises after the snapshot waits for the next frame.
//  - Timeout: SERVE held TIMEOUT cycles without done -> overrun=1, treat as done
//    (pending[i] cleared, rr_ptr <= i, go to ARB).
//  - Active-region guard: VCounter==V_ACTIVE_START while state!=IDLE -> grant <= 0, pending <= 0,
//    overrun=1, state <= IDLE next cycle.
//  - Event while state!=IDLE -> overrun=1; the current frame continues and no new snapshot is taken.
//  - enable falling mid-frame: the current grant completes, remaining pending slots are still served;
//    enable is only sampled at the event.
//  - overrun is sticky. clr_overrun clears it on the next cycle; a set condition in the same cycle wins.
//  - grant is never multi-hot. grant!=0 only in SERVE.
//  - busy is combinational from state.
// TESTING
//  1 Reset: assert rst_n=0 mid-SERVE -> grant=0, busy=0, overrun=0, frame_count=0 in the same cycle.
//  2 Basic frame: req=4'b0101, VCounter 515->516 with HCounter=0 held 4 clk
//    -> one frame_tick; grant=0001 until done[0]; then 0100; then idle; frame_count=1.
//  3 Round-robin across frames: req=4'b1111 for 2 frames, each done 3 cycles after grant
//    -> frame 1 grant order 0,1,2,3; frame 2 order 0,1,2,3; rr_ptr=3 at the end of each frame.
//  4 Timeout: req=4'b0010, never pulse done -> grant=0010 for exactly 4095 cycles, then 0; overrun=1.
//  5 Active guard: req=4'b0001 with no done until VCounter wraps to 36 -> grant drops, state IDLE,
//    overrun=1; clr_overrun -> overrun=0.
//  6 enable=0 at the event -> frame_tick pulses and frame_count increments, grant stays 0;
//    frame_count wraps 255->0 after 256 events.

Source files
------------

// File: rtl/frame_update_scheduler.sv
// Round-robin update-slot scheduler: snapshots requesters at vblank start and grants one
// requester at a time, so object state only changes outside the visible region.
module frame_update_scheduler #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned V_ACTIVE_START = 36,
    parameter int unsigned V_ACTIVE_END   = 515,
    parameter int unsigned TIMEOUT        = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [9:0]       HCounter,
    input  logic [9:0]       VCounter,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic             clr_overrun,
    output logic [N_REQ-1:0] grant,
    output logic             frame_tick,
    output logic             busy,
    output logic             overrun,
    output logic [7:0]       frame_count
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StArb, StServe} state_e;

    state_e           state_q;
    logic             vb_q;
    logic [N_REQ-1:0] pending_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    cur_q;
    logic [TW-1:0]    timer_q;

    logic          vb;
    logic          vb_event;
    logic          guard;
    logic          served;
    logic          timeout_hit;
    logic          set_overrun;
    logic          arb_found;
    logic [IW-1:0] arb_idx;
    logic [IW-1:0] cand;

    // Counters hold each value for many clk cycles, so only the rising edge of vb counts.
    assign vb          = (VCounter == 10'(V_ACTIVE_END + 1)) && (HCounter == 10'd0);
    assign vb_event    = vb && !vb_q;
    assign busy        = (state_q != StIdle);
    assign guard       = (VCounter == 10'(V_ACTIVE_START)) && busy;
    assign served      = done[cur_q];
    assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));
    assign set_overrun = guard || (vb_event && busy) ||
                         ((state_q == StServe) && !served && timeout_hit);

    // Search starts just after the last served requester.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(rr_ptr_q) + k) % N_REQ);
            if (!arb_found && pending_q[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vb_q        <= 1'b0;
            pending_q   <= '0;
            rr_ptr_q    <= IW'(N_REQ - 1);
            cur_q       <= '0;
            timer_q     <= '0;
            grant       <= '0;
            frame_tick  <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            vb_q       <= vb;
            frame_tick <= vb_event;
            if (vb_event) begin
                frame_count <= frame_count + 8'd1;
            end

            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            if (guard) begin
                grant     <= '0;
                pending_q <= '0;
                state_q   <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (vb_event && enable) begin
                            pending_q <= req;
                            state_q   <= StArb;
                        end
                    end
                    StArb: begin
                        if (arb_found) begin
                            grant   <= N_REQ'(1) << arb_idx;
                            cur_q   <= arb_idx;
                            timer_q <= '0;
                            state_q <= StServe;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StServe: begin
                        // A timeout retires the slot exactly like a done.
                        if (served || timeout_hit) begin
                            grant            <= '0;
                            pending_q[cur_q] <= 1'b0;
                            rr_ptr_q         <= cur_q;
                            state_q          <= StArb;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench for frame_update_scheduler: queue-based frame model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_frame_update_scheduler;

    localparam int N  = 4;
    localparam int TO = 4095;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       enable      = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [9:0] HCounter    = 10'd5;
    logic [9:0] VCounter    = 10'd100;
    logic [3:0] req         = 4'b0000;
    logic [3:0] done        = 4'b0000;
    logic [3:0] grant;
    logic       frame_tick;
    logic       busy;
    logic       overrun;
    logic [7:0] frame_count;

    frame_update_scheduler #(
        .N_REQ         (4),
        .V_ACTIVE_START(36),
        .V_ACTIVE_END  (515),
        .TIMEOUT       (4095)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .HCounter   (HCounter),
        .VCounter   (VCounter),
        .req        (req),
        .done       (done),
        .clr_overrun(clr_overrun),
        .grant      (grant),
        .frame_tick (frame_tick),
        .busy       (busy),
        .overrun    (overrun),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h time=%0t", name, got, exp, $time);
        end
    endtask

    // Frame model: a snapshot becomes an ordered service queue, served one slot at a time
    // with one empty cycle between slots.
    int   m_q[$];
    int   m_rr   = N - 1;
    int   m_cur  = -1;
    int   m_held = 0;
    int   m_idx;
    bit   m_busy = 1'b0;
    bit   m_tick = 1'b0;
    bit   m_ovr  = 1'b0;
    bit   m_vbq  = 1'b0;
    bit   m_vb;
    bit   m_ev;
    bit   m_set;
    logic [7:0] m_fc = 8'd0;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_rr = N - 1; m_cur = -1; m_held = 0;
                m_busy = 1'b0; m_tick = 1'b0; m_ovr = 1'b0; m_vbq = 1'b0; m_fc = 8'd0;
            end else begin
                m_vb  = (VCounter == 10'd516) && (HCounter == 10'd0);
                m_ev  = m_vb && !m_vbq;
                m_vbq = m_vb;
                m_set = 1'b0;
                if (m_busy && VCounter == 10'd36) begin
                    m_q.delete();
                    m_cur  = -1;
                    m_busy = 1'b0;
                    m_set  = 1'b1;
                end else if (m_busy) begin
                    if (m_ev) m_set = 1'b1;
                    if (m_cur >= 0) begin
                        m_held++;
                        if (done[m_cur[1:0]]) begin
                            m_rr  = m_cur;
                            m_cur = -1;
                        end else if (m_held == TO) begin
                            m_set = 1'b1;
                            m_rr  = m_cur;
                            m_cur = -1;
                        end
                    end else if (m_q.size() == 0) begin
                        m_busy = 1'b0;
                    end else begin
                        m_cur  = m_q.pop_front();
                        m_held = 0;
                    end
                end else if (m_ev && enable) begin
                    for (int k = 1; k <= N; k++) begin
                        m_idx = (m_rr + k) % N;
                        if (req[m_idx[1:0]]) m_q.push_back(m_idx);
                    end
                    m_busy = 1'b1;
                    m_cur  = -1;
                end
                m_tick = m_ev;
                if (m_ev) m_fc = m_fc + 8'd1;
                if (m_set) m_ovr = 1'b1;
                else if (clr_overrun) m_ovr = 1'b0;
            end
        end
    end

    initial begin : compare
        logic [3:0] eg;
        forever begin
            @(negedge clk);
            eg = 4'b0000;
            if (m_cur >= 0) eg[m_cur[1:0]] = 1'b1;
            if (frame_tick) tick_cnt++;
            check("cyc_grant", int'(grant), int'(eg));
            check("cyc_tick", int'(frame_tick), int'(m_tick));
            check("cyc_busy", int'(busy), int'(m_busy));
            check("cyc_overrun", int'(overrun), int'(m_ovr));
            check("cyc_fcount", int'(frame_count), int'(m_fc));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_event(input int hold);
        VCounter = 10'd516;
        HCounter = 10'd0;
        tick(hold);
        VCounter = 10'd100;
        HCounter = 10'd5;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int k = 0; k < 40 && idx < 0; k++) begin
            if (grant != 4'b0000) begin
                for (int b = 0; b < N; b++) if (grant[b]) idx = b;
            end else begin
                tick(1);
            end
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_grant got=none exp=grant within 40 cycles time=%0t", $time);
        end
    endtask

    task automatic pulse_done(input int i);
        done[i[1:0]] = 1'b1;
        tick(1);
        done = 4'b0000;
    endtask

    int idx;
    int cnt;
    int base;

    initial begin : stim
        tick(3);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_fcount", int'(frame_count), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(2);

        // Basic frame: 0101 -> slot 0 then slot 2.
        req = 4'b0101;
        do_event(4);
        wait_grant(idx);
        check("t2_first", idx, 0);
        check("t2_fcount", int'(frame_count), 1);
        check("t2_ticks", tick_cnt, 1);
        done = 4'b0100;
        tick(1);
        done = 4'b0000;
        tick(1);
        check("t2_ignore_done", int'(grant), 4'b0001);
        pulse_done(0);
        wait_grant(idx);
        check("t2_second", int'(grant), 4'b0100);
        pulse_done(2);
        tick(3);
        check("t2_idle_busy", int'(busy), 0);
        check("t2_idle_grant", int'(grant), 0);

        // Reset mid-SERVE.
        req = 4'b0001;
        do_event(4);
        wait_grant(idx);
        check("t1_pre_grant", idx, 0);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_grant", int'(grant), 0);
        check("t1_busy", int'(busy), 0);
        check("t1_overrun", int'(overrun), 0);
        check("t1_fcount", int'(frame_count), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Round-robin over two frames from the reset pointer.
        req = 4'b1111;
        for (int f = 0; f < 2; f++) begin
            do_event(4);
            for (int j = 0; j < N; j++) begin
                wait_grant(idx);
                check("t3_order", idx, j);
                tick(2);
                pulse_done(idx);
            end
            tick(4);
            check("t3_busy_end", int'(busy), 0);
            check("t3_fcount", int'(frame_count), f + 1);
        end

        // Timeout; req drops after the snapshot but keeps its slot.
        req = 4'b0010;
        do_event(2);
        req = 4'b0000;
        wait_grant(idx);
        check("t4_idx", idx, 1);
        cnt = 0;
        while (grant == 4'b0010 && cnt < 5000) begin
            cnt++;
            tick(1);
        end
        check("t4_len", cnt, 4095);
        check("t4_overrun", int'(overrun), 1);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("t4_clr", int'(overrun), 0);

        // Active-region guard.
        req = 4'b0001;
        do_event(2);
        wait_grant(idx);
        check("t5_idx", idx, 0);
        tick(3);
        VCounter = 10'd36;
        tick(1);
        VCounter = 10'd100;
        check("t5_grant", int'(grant), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_overrun", int'(overrun), 1);
        tick(2);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("t5_clr", int'(overrun), 0);

        // Disabled frames still tick and count; counter wraps.
        enable = 1'b0;
        req    = 4'b1111;
        base   = tick_cnt;
        do_event(1);
        tick(1);
        check("t6_fcount", int'(frame_count), 5);
        check("t6_grant", int'(grant), 0);
        check("t6_busy", int'(busy), 0);
        for (int e = 0; e < 256; e++) begin
            VCounter = 10'd516;
            HCounter = 10'd0;
            tick(1);
            VCounter = 10'd100;
            tick(1);
        end
        tick(1);
        check("t6_wrap", int'(frame_count), 5);
        check("t6_ticks", tick_cnt - base, 257);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
